// File: rtl/xnor_based_serial_subtractor16.sv
// rtl/xnor_based_serial_subtractor16.sv - digit-serial approximate subtractor with XNOR low cells
//
// Computes A - B as A + ~B + 1, DIGIT bits per cycle. Difference bits below
// LOWER_WIDTH come out inverted (XNOR cell output); the carry chain is exact.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   valid_i   operand pair valid
//   ready_o   block can accept operands (IDLE)
//   sub1_i    minuend A
//   sub2_i    subtrahend B
//   valid_o   result valid (DONE)
//   ready_i   downstream accepts result
//   result_o  {carry_out, diff}; carry_out=1 means no borrow
module xnor_based_serial_subtractor16 #(
    parameter int WIDTH       = 16,
    parameter int LOWER_WIDTH = 4,
    parameter int DIGIT       = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] sub1_i,
    input  logic [WIDTH-1:0] sub2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;      // holds ~B so the datapath is a plain adder
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;

    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] approx_mask;
    logic [DIGIT-1:0] digit_out;
    logic [WIDTH-1:0] diff_next;

    // Operands shift right each BUSY cycle, so the current digit is always
    // the bottom DIGIT bits; finished digits enter diff_q from the top.
    always_comb begin
        sum         = {1'b0, a_q[DIGIT-1:0]} + {1'b0, nb_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
        approx_mask = '0;
        for (int j = 0; j < DIGIT; j++) begin
            approx_mask[j] = ((int'(cnt_q) * DIGIT + j) < LOWER_WIDTH);
        end
        // Only the sum bit is inverted; sum[DIGIT] stays exact for the chain.
        digit_out   = sum[DIGIT-1:0] ^ approx_mask;
        diff_next   = (diff_q >> DIGIT) | (WIDTH'(digit_out) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            a_q      <= '0;
            nb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= sub1_i;
                        nb_q    <= ~sub2_i;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        diff_q  <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> DIGIT;
                    nb_q    <= nb_q >> DIGIT;
                    carry_q <= sum[DIGIT];
                    diff_q  <= diff_next;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        result_o <= {sum[DIGIT], diff_next};
                        cnt_q    <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // valid_o is high throughout DONE, so ready_i completes
                    // the output handshake; no operand is taken this cycle.
                    if (ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

endmodule
